// File: rtl/ram_arbiter_if.sv
// Bus bundle between the work-RAM arbiter and its environment.
// The environment side covers both requesters (CPU, video) and the RAM port.
interface ram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
);
    logic                  clear_start;
    logic                  clear_busy;
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic                  vid_req;
    logic [ADDR_WIDTH-1:0] vid_addr;
    logic                  vid_gnt;
    logic                  vid_rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_wren;
    logic [DATA_WIDTH-1:0] ram_q;

    // Arbiter side
    modport slave (
        input  clear_start, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               vid_req, vid_addr, ram_q,
        output clear_busy, cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid,
               rdata, ram_address, ram_data, ram_wren
    );

    // Requesters plus RAM side
    modport master (
        output clear_start, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               vid_req, vid_addr, ram_q,
        input  clear_busy, cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid,
               rdata, ram_address, ram_data, ram_wren
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one work-RAM port between the CPU and the
// video fetch logic, with a sweep engine that fills the whole RAM with
// FILL_VALUE after reset or on a clear_start pulse.
module ram_arbiter #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 9,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE     = '0
) (
    input  logic          clock,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);

    typedef enum logic {SWEEP, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] counter_reg;
    logic                  vid_next_reg;   // 1: video wins the next tie
    logic                  cpu_rvalid_reg;
    logic                  vid_rvalid_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;       // last driven address, held when idle

    logic                  in_run;
    logic                  cpu_gnt_next;
    logic                  vid_gnt_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  wren_next;

    // Grant decision and RAM port muxing for the current cycle
    always_comb begin
        in_run       = (state_reg == RUN);
        cpu_gnt_next = in_run && bus.cpu_req && (!bus.vid_req || !vid_next_reg);
        vid_gnt_next = in_run && bus.vid_req && (!bus.cpu_req || vid_next_reg);
        addr_next    = addr_reg;
        data_next    = bus.cpu_wdata;
        wren_next    = 1'b0;
        if (!in_run) begin
            addr_next = counter_reg;
            data_next = FILL_VALUE;
            wren_next = 1'b1;
        end else if (cpu_gnt_next) begin
            addr_next = bus.cpu_addr;
            wren_next = bus.cpu_we;
        end else if (vid_gnt_next) begin
            addr_next = bus.vid_addr;
        end
    end

    // Sweep/run state, round-robin pointer and read-response strobes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= CLEAR_ON_RESET ? SWEEP : RUN;
            counter_reg    <= '0;
            vid_next_reg   <= 1'b0;
            cpu_rvalid_reg <= 1'b0;
            vid_rvalid_reg <= 1'b0;
            addr_reg       <= '0;
        end else begin
            addr_reg       <= addr_next;
            cpu_rvalid_reg <= cpu_gnt_next && !bus.cpu_we;
            vid_rvalid_reg <= vid_gnt_next;
            if (cpu_gnt_next || vid_gnt_next) begin
                vid_next_reg <= cpu_gnt_next;
            end
            case (state_reg)
                SWEEP: begin
                    counter_reg <= counter_reg + 1'b1;
                    if (counter_reg == LAST_ADDR) begin
                        state_reg <= RUN;
                    end
                end
                default: begin
                    if (bus.clear_start) begin
                        state_reg   <= SWEEP;
                        counter_reg <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.cpu_gnt     = cpu_gnt_next;
    assign bus.vid_gnt     = vid_gnt_next;
    assign bus.cpu_rvalid  = cpu_rvalid_reg;
    assign bus.vid_rvalid  = vid_rvalid_reg;
    assign bus.clear_busy  = (state_reg == SWEEP);
    assign bus.rdata       = bus.ram_q;
    assign bus.ram_address = addr_next;
    assign bus.ram_data    = data_next;
    assign bus.ram_wren    = wren_next;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: models the 512x8 RAM with registered read,
// runs a vector table, multi-cycle sweep/reset sequences and a randomized
// phase compared against a behavioural arbitration and memory model.
module tb_ram_arbiter;

    logic clock;
    logic reset;
    logic [7:0] mem [512];

    int tests = 0;
    int fails = 0;

    ram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) bus ();

    ram_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Work RAM: one port, registered read, old data on read-during-write
    always @(posedge clock) begin
        if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_address];
    end

    typedef struct {
        logic       cr;
        logic       cw;
        logic [8:0] ca;
        logic [7:0] cd;
        logic       vr;
        logic [8:0] va;
        logic       ecg;
        logic       evg;
        logic       ew;
        logic [8:0] eaddr;
        logic       ecrv;
        logic       evrv;
        logic [7:0] erd;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Count sweep cycles (clear_busy high at mid-cycle) and any grant seen
    // meanwhile; returns at the mid-cycle point of the first RUN cycle.
    task automatic wait_sweep(output int cnt, output int gseen, input int pulse_at);
        cnt = 0;
        gseen = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (!bus.clear_busy) return;
            cnt++;
            if (bus.cpu_gnt || bus.vid_gnt) gseen++;
            tick();
            bus.clear_start = (cnt == pulse_at);
        end
    endtask

    task automatic idle_inputs();
        bus.clear_start = 1'b0;
        bus.cpu_req     = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_addr    = '0;
        bus.cpu_wdata   = '0;
        bus.vid_req     = 1'b0;
        bus.vid_addr    = '0;
    endtask

    // Random-phase reference state
    logic [7:0] sh [512];
    logic       last_vid;
    logic       c_pend, v_pend;
    logic       creq, cwe, vreq;
    logic [8:0] caddr, vaddr;
    logic [7:0] cdata;
    logic       e_cg, e_vg, e_crv, e_vrv, n_crv, n_vrv;
    logic [7:0] e_rd, n_rd;

    initial begin
        int cnt, gseen, nz;

        tbl[0]  = '{1'b1, 1'b1, 9'h1F3, 8'hA5, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 9'h1F3, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 9'h1F3, 8'h00, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 9'h1F3, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h1F3, 1'b1, 1'b0, 8'hA5};
        tbl[3]  = '{1'b1, 1'b1, 9'h010, 8'h3C, 1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 9'h010, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, 9'h000, 8'h00, 1'b1, 9'h010, 1'b0, 1'b1, 1'b0, 9'h010, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b1, 8'h3C};
        tbl[6]  = '{1'b1, 1'b0, 9'h1F3, 8'h00, 1'b1, 9'h010, 1'b1, 1'b0, 1'b0, 9'h1F3, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 1'b0, 9'h1F3, 8'h00, 1'b1, 9'h010, 1'b0, 1'b1, 1'b0, 9'h010, 1'b1, 1'b0, 8'hA5};
        tbl[8]  = '{1'b1, 1'b0, 9'h1F3, 8'h00, 1'b1, 9'h010, 1'b1, 1'b0, 1'b0, 9'h1F3, 1'b0, 1'b1, 8'h3C};
        tbl[9]  = '{1'b1, 1'b0, 9'h1F3, 8'h00, 1'b1, 9'h010, 1'b0, 1'b1, 1'b0, 9'h010, 1'b1, 1'b0, 8'hA5};
        tbl[10] = '{1'b1, 1'b0, 9'h1F3, 8'h00, 1'b1, 9'h010, 1'b1, 1'b0, 1'b0, 9'h1F3, 1'b0, 1'b1, 8'h3C};
        tbl[11] = '{1'b1, 1'b0, 9'h1F3, 8'h00, 1'b1, 9'h010, 1'b0, 1'b1, 1'b0, 9'h010, 1'b1, 1'b0, 8'hA5};
        tbl[12] = '{1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h010, 1'b0, 1'b1, 8'h3C};

        for (int i = 0; i < 512; i++) mem[i] = 8'hFF;
        idle_inputs();
        reset = 1'b1;
        #2;
        chk("reset_busy", bus.clear_busy, 1);
        chk("reset_rvalids", {bus.cpu_rvalid, bus.vid_rvalid}, 0);

        // Reset release: full sweep with the CPU request held off
        tick();
        reset = 1'b0;
        bus.cpu_req = 1'b1;
        wait_sweep(cnt, gseen, -1);
        $display("[TB] reset sweep: %0d busy cycles, %0d grants", cnt, gseen);
        chk("reset_sweep_len", cnt, 512);
        chk("reset_sweep_grants", gseen, 0);
        chk("first_run_cpu_gnt", bus.cpu_gnt, 1);
        nz = 0;
        for (int i = 0; i < 512; i++) if (mem[i] != 8'h00) nz++;
        chk("dump_nonzero_words", nz, 0);
        tick();

        // Vector table: single writes/reads, cross-cycle hazard, tie rotation
        for (int r = 0; r < 13; r++) begin
            bus.cpu_req   = tbl[r].cr;
            bus.cpu_we    = tbl[r].cw;
            bus.cpu_addr  = tbl[r].ca;
            bus.cpu_wdata = tbl[r].cd;
            bus.vid_req   = tbl[r].vr;
            bus.vid_addr  = tbl[r].va;
            @(negedge clock);
            $display("[TB] vec %0d: cgnt=%0b vgnt=%0b wren=%0b addr=%03h crv=%0b vrv=%0b rdata=%02h",
                     r, bus.cpu_gnt, bus.vid_gnt, bus.ram_wren, bus.ram_address,
                     bus.cpu_rvalid, bus.vid_rvalid, bus.rdata);
            chk($sformatf("vec%0d_cpu_gnt", r), bus.cpu_gnt, tbl[r].ecg);
            chk($sformatf("vec%0d_vid_gnt", r), bus.vid_gnt, tbl[r].evg);
            chk($sformatf("vec%0d_wren", r), bus.ram_wren, tbl[r].ew);
            chk($sformatf("vec%0d_addr", r), bus.ram_address, tbl[r].eaddr);
            chk($sformatf("vec%0d_cpu_rvalid", r), bus.cpu_rvalid, tbl[r].ecrv);
            chk($sformatf("vec%0d_vid_rvalid", r), bus.vid_rvalid, tbl[r].evrv);
            if (tbl[r].ew) chk($sformatf("vec%0d_wdata", r), bus.ram_data, tbl[r].cd);
            if (tbl[r].ecrv || tbl[r].evrv) chk($sformatf("vec%0d_rdata", r), bus.rdata, tbl[r].erd);
            tick();
        end

        // clear_start in RUN while video reads; in-flight rvalid survives
        idle_inputs();
        bus.vid_req     = 1'b1;
        bus.vid_addr    = 9'h010;
        bus.clear_start = 1'b1;
        @(negedge clock);
        chk("clr_vid_gnt", bus.vid_gnt, 1);
        tick();
        bus.clear_start = 1'b0;
        bus.vid_addr    = 9'h1F3;
        #2;
        chk("clr_busy", bus.clear_busy, 1);
        chk("clr_inflight_rvalid", bus.vid_rvalid, 1);
        chk("clr_inflight_rdata", bus.rdata, 8'h3C);
        wait_sweep(cnt, gseen, 100);
        $display("[TB] clear sweep: %0d busy cycles, %0d grants", cnt, gseen);
        chk("clr_sweep_len", cnt, 512);
        chk("clr_sweep_grants", gseen, 0);
        chk("clr_first_run_vid_gnt", bus.vid_gnt, 1);
        chk("clr_first_run_addr", bus.ram_address, 9'h1F3);
        tick();
        bus.vid_req = 1'b0;
        #2;
        chk("clr_post_rvalid", bus.vid_rvalid, 1);
        chk("clr_post_rdata", bus.rdata, 8'h00);
        tick();

        // Randomized traffic against a behavioural model
        for (int i = 0; i < 512; i++) sh[i] = 8'h00;
        last_vid = 1'b1;
        c_pend = 1'b0; v_pend = 1'b0;
        e_crv = 1'b0; e_vrv = 1'b0; e_rd = 8'h00;
        creq = 1'b0; cwe = 1'b0; caddr = '0; cdata = '0; vreq = 1'b0; vaddr = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!c_pend) begin
                creq  = ($urandom_range(0, 2) != 0);
                cwe   = $urandom_range(0, 1) == 1;
                caddr = 9'($urandom_range(0, 15));
                cdata = 8'($urandom);
            end
            if (!v_pend) begin
                vreq  = ($urandom_range(0, 2) != 0);
                vaddr = 9'($urandom_range(0, 15));
            end
            bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cdata;
            bus.vid_req = vreq; bus.vid_addr = vaddr;
            @(negedge clock);
            // A lone requester wins; on a tie the side not served last wins
            e_cg = creq && (!vreq || last_vid);
            e_vg = vreq && !e_cg;
            chk("rnd_cpu_gnt", bus.cpu_gnt, e_cg);
            chk("rnd_vid_gnt", bus.vid_gnt, e_vg);
            chk("rnd_cpu_rvalid", bus.cpu_rvalid, e_crv);
            chk("rnd_vid_rvalid", bus.vid_rvalid, e_vrv);
            if (e_crv || e_vrv) chk("rnd_rdata", bus.rdata, e_rd);
            chk("rnd_wren", bus.ram_wren, e_cg && cwe);
            if (e_cg) chk("rnd_cpu_addr", bus.ram_address, caddr);
            if (e_vg) chk("rnd_vid_addr", bus.ram_address, vaddr);
            if (e_cg && cwe) chk("rnd_wdata", bus.ram_data, cdata);
            n_crv = 1'b0; n_vrv = 1'b0; n_rd = 8'h00;
            if (e_cg) begin
                last_vid = 1'b0;
                if (cwe) sh[caddr] = cdata;
                else begin n_crv = 1'b1; n_rd = sh[caddr]; end
            end
            if (e_vg) begin
                last_vid = 1'b1;
                n_vrv = 1'b1;
                n_rd  = sh[vaddr];
            end
            e_crv = n_crv; e_vrv = n_vrv; e_rd = n_rd;
            c_pend = creq && !e_cg;
            v_pend = vreq && !e_vg;
            tick();
        end
        $display("[TB] random phase done: %0d tests so far, %0d failed", tests, fails);
        idle_inputs();
        tick();

        // CPU read with clear_start, then reset mid-sweep at counter 200
        bus.cpu_req     = 1'b1;
        bus.cpu_addr    = 9'd5;
        bus.clear_start = 1'b1;
        @(negedge clock);
        chk("rst_cpu_gnt", bus.cpu_gnt, 1);
        tick();
        bus.clear_start = 1'b0;
        bus.cpu_req     = 1'b0;
        #2;
        chk("rst_first_sweep_rvalid", bus.cpu_rvalid, 1);
        chk("rst_first_sweep_rdata", bus.rdata, sh[5]);
        chk("rst_first_sweep_addr", bus.ram_address, 0);
        for (int i = 0; i < 200; i++) tick();
        #2;
        chk("rst_counter_200", bus.ram_address, 9'd200);
        bus.cpu_req = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_async_addr", bus.ram_address, 0);
        chk("rst_async_busy", bus.clear_busy, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("rst_hold_rvalids", {bus.cpu_rvalid, bus.vid_rvalid}, 0);
        end
        tick();
        reset = 1'b0;
        chk("rst_restart_addr", bus.ram_address, 0);
        wait_sweep(cnt, gseen, -1);
        $display("[TB] restart sweep: %0d busy cycles, %0d grants", cnt, gseen);
        chk("rst_sweep_len", cnt, 512);
        chk("rst_sweep_grants", gseen, 0);
        chk("rst_first_run_cpu_gnt", bus.cpu_gnt, 1);
        tick();
        idle_inputs();
        tick();

        // Reset between a video grant and its response cancels the rvalid
        bus.vid_req  = 1'b1;
        bus.vid_addr = 9'd3;
        @(negedge clock);
        chk("midread_vid_gnt", bus.vid_gnt, 1);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #2;
        chk("midread_rvalid_cancel", bus.vid_rvalid, 0);
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
